tlc_vehicle_detect: RTL and testbench

//  Conditions the raw East-West inductive-loop sensor into the clean, glitch-free

---
 rtl/tlc_pkg.sv | 20 ++
 rtl/tlc_sync.sv | 28 ++
 rtl/tlc_vehicle_detect.sv | 154 +++++++++++++++
 tb/tb_tlc_vehicle_detect.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light vehicle-detect conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlc_pkg;

   // Conditioner states; 3-bit encoding leaves two codes unused, which the
   // FSM treats as illegal and recovers from by returning to ST_IDLE.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_QUAL_ON  = 3'd1,
      ST_PRESENT  = 3'd2,
      ST_QUAL_OFF = 3'd3,
      ST_HOLD     = 3'd4,
      ST_FAULT    = 3'd5
   } vd_state_t;

   // Width of the saturating vehicle-arrival counter.
   localparam int TLC_VD_CNT_W = 16;

endpackage

// File: rtl/tlc_sync.sv
// Multi-flop synchroniser for a single asynchronous level into i_clk.
// Latency: STAGES edges from input change to sync_out change.
// Backpressure: none, free-running.
//
// Ports: i_clk, i_rst (sync, active-high, clears chain to 0),
//        async_in (asynchronous level), sync_out (synchronised level).
module tlc_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/tlc_vehicle_detect.sv
// Conditions the raw East-West loop sensor into a glitch-free detect level.
// Latency: rise SYNC_STAGES+DEBOUNCE_CYC+1 edges; fall adds HOLD_CYC more.
// Backpressure: none; sensor sampled every cycle, outputs are levels/strobes.
//
// Ports: i_clk, i_rst (sync, active-high), i_loop_raw (async loop sensor),
//        o_ew_vd (conditioned detect), o_vd_pulse (one-cycle arrival strobe),
//        o_fault (loop stuck-on), and with TLC_VD_COUNT_EN defined:
//        i_cnt_clr (clear counter), o_veh_count (saturating arrival count).
module tlc_vehicle_detect
   import tlc_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 8,
   parameter int HOLD_CYC     = 16,
   parameter int STUCK_CYC    = 1000,
   parameter int CNT_W        = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_loop_raw,
   output logic                    o_ew_vd,
   output logic                    o_vd_pulse,
   output logic                    o_fault
`ifdef TLC_VD_COUNT_EN
   ,
   input  logic                    i_cnt_clr,
   output logic [TLC_VD_CNT_W-1:0] o_veh_count
`endif
);

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYC - 1);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   logic             loop_s;
   vd_state_t        state;
   logic [CNT_W-1:0] tmr;
   logic [CNT_W-1:0] stuck;

   tlc_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .async_in (i_loop_raw),
      .sync_out (loop_s)
   );

   // Outputs are updated alongside the state so they always describe the
   // state being entered on this edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         tmr        <= '0;
         stuck      <= '0;
         o_ew_vd    <= 1'b0;
         o_vd_pulse <= 1'b0;
         o_fault    <= 1'b0;
      end else begin
         o_vd_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (loop_s) begin
                  state <= ST_QUAL_ON;
                  tmr   <= '0;
               end
            end
            ST_QUAL_ON: begin
               if (!loop_s) begin
                  state <= ST_IDLE;
               end else if (tmr == DEB_LAST) begin
                  state      <= ST_PRESENT;
                  stuck      <= '0;
                  o_ew_vd    <= 1'b1;
                  o_vd_pulse <= 1'b1;
               end else begin
                  tmr <= tmr + ONE;
               end
            end
            ST_PRESENT: begin
               // Stuck-on detection takes priority over a release.
               if (stuck == STUCK_LAST) begin
                  state   <= ST_FAULT;
                  tmr     <= '0;
                  o_fault <= 1'b1;
               end else begin
                  stuck <= stuck + ONE;
                  if (!loop_s) begin
                     state <= ST_QUAL_OFF;
                     tmr   <= '0;
                  end
               end
            end
            ST_QUAL_OFF: begin
               // A bounce back to presence is the same vehicle: stuck
               // accumulation continues and no new arrival is strobed.
               if (loop_s) begin
                  state <= ST_PRESENT;
               end else if (tmr == DEB_LAST) begin
                  state <= ST_HOLD;
                  tmr   <= '0;
               end else begin
                  tmr <= tmr + ONE;
               end
            end
            ST_HOLD: begin
               if (loop_s) begin
                  state      <= ST_PRESENT;
                  stuck      <= '0;
                  o_vd_pulse <= 1'b1;
               end else if (tmr == HOLD_LAST) begin
                  state   <= ST_IDLE;
                  o_ew_vd <= 1'b0;
               end else begin
                  tmr <= tmr + ONE;
               end
            end
            ST_FAULT: begin
               // Detect stays asserted (fail safe) until a clean release;
               // the exit skips the hold stretch.
               if (loop_s) begin
                  tmr <= '0;
               end else if (tmr == DEB_LAST) begin
                  state   <= ST_IDLE;
                  o_ew_vd <= 1'b0;
                  o_fault <= 1'b0;
               end else begin
                  tmr <= tmr + ONE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               tmr     <= '0;
               stuck   <= '0;
               o_ew_vd <= 1'b0;
               o_fault <= 1'b0;
            end
         endcase
      end
   end

`ifdef TLC_VD_COUNT_EN
   // Counts each arrival strobe; a clear coinciding with a strobe wins.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
         o_veh_count <= '0;
      end else if (o_vd_pulse && (o_veh_count != {TLC_VD_CNT_W{1'b1}})) begin
         o_veh_count <= o_veh_count + TLC_VD_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_tlc_vehicle_detect.sv
// Testbench for tlc_vehicle_detect: directed scenarios plus randomized loop
// activity, every cycle compared against a run-length reference model.
// Build with or without TLC_VD_COUNT_EN; counter checks follow the macro.
module tb_tlc_vehicle_detect;

   localparam int SYNC  = 2;
   localparam int DEB   = 8;
   localparam int HOLD  = 16;
   localparam int STUCK = 100;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_loop_raw = 1'b0;
   logic        o_ew_vd;
   logic        o_vd_pulse;
   logic        o_fault;
   logic        i_cnt_clr = 1'b0;
   logic [15:0] o_veh_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 i_clk = ~i_clk;

   tlc_vehicle_detect #(
      .SYNC_STAGES  (SYNC),
      .DEBOUNCE_CYC (DEB),
      .HOLD_CYC     (HOLD),
      .STUCK_CYC    (STUCK),
      .CNT_W        (10)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_loop_raw  (i_loop_raw),
      .o_ew_vd     (o_ew_vd),
      .o_vd_pulse  (o_vd_pulse),
      .o_fault     (o_fault)
`ifdef TLC_VD_COUNT_EN
      ,
      .i_cnt_clr   (i_cnt_clr),
      .o_veh_count (o_veh_count)
`endif
   );

`ifndef TLC_VD_COUNT_EN
   assign o_veh_count = 16'h0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: tracks the loop as run lengths of the synchronised
   // level instead of an explicit state machine.
   logic [SYNC-1:0] m_sync;
   bit   m_active, m_fault, e_pulse;
   int   hi_run, lo_run, flt_lo, pres_age;
   logic [15:0] e_cnt;

   task automatic model_step(input logic raw, input logic rst, input logic clr);
      logic s;
      bit   was_pulse;
      bit   in_present;
      s         = m_sync[SYNC-1];
      m_sync    = {m_sync[SYNC-2:0], raw};
      was_pulse = e_pulse;
      if (rst) begin
         m_sync = '0; m_active = 0; m_fault = 0; e_pulse = 0;
         hi_run = 0; lo_run = 0; flt_lo = 0; pres_age = 0; e_cnt = '0;
         return;
      end
      if (clr) e_cnt = '0;
      else if (was_pulse && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      e_pulse = 0;
      if (m_fault) begin
         if (s) flt_lo = 0;
         else begin
            flt_lo++;
            if (flt_lo == DEB) begin m_fault = 0; m_active = 0; hi_run = 0; end
         end
      end else if (!m_active) begin
         if (s) begin
            hi_run++;
            if (hi_run == DEB + 1) begin
               m_active = 1; e_pulse = 1; pres_age = 0; lo_run = 0;
            end
         end else hi_run = 0;
      end else begin
         // Loop currently counted as occupied when no low run is in progress.
         in_present = (lo_run == 0);
         if (in_present && pres_age == STUCK - 1) begin
            m_fault = 1; flt_lo = 0;
         end else begin
            if (in_present) pres_age++;
            if (s) begin
               if (lo_run >= DEB + 1) begin e_pulse = 1; pres_age = 0; end
               lo_run = 0;
            end else begin
               lo_run++;
               if (lo_run == DEB + HOLD + 1) begin m_active = 0; hi_run = 0; end
            end
         end
      end
   endtask

   task automatic tick(input logic raw, input logic rst, input logic clr);
      @(negedge i_clk);
      i_loop_raw = raw;
      i_rst      = rst;
      i_cnt_clr  = clr;
      @(posedge i_clk);
      model_step(raw, rst, clr);
      #1;
      chk("vd", o_ew_vd, m_active | m_fault);
      chk("pulse", o_vd_pulse, e_pulse);
      chk("fault", o_fault, m_fault);
`ifdef TLC_VD_COUNT_EN
      chk("count", o_veh_count, e_cnt);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int edges;
      int npulse;
      bit vd_dropped;
      logic raw;
      int len;
      int r;

      // Reset state
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      chk("rst_vd", o_ew_vd, 0);
      chk("rst_pulse", o_vd_pulse, 0);
      chk("rst_fault", o_fault, 0);
      repeat (3) tick(1'b0, 1'b0, 1'b0);

      // 1: held rise -> detect after 11 edges, single strobe
      edges = 0;
      do begin tick(1'b1, 1'b0, 1'b0); edges++; end while (!o_ew_vd && edges < 40);
      chk("rise_latency", edges, SYNC + DEB + 1);
      chk("rise_pulse_on", o_vd_pulse, 1);
      tick(1'b1, 1'b0, 1'b0);
      chk("rise_pulse_off", o_vd_pulse, 0);
      repeat (4) tick(1'b1, 1'b0, 1'b0);
`ifdef TLC_VD_COUNT_EN
      chk("count_one", o_veh_count, 1);
`endif

      // 3: short dropout while present is absorbed
      npulse = 0; vd_dropped = 0;
      repeat (4) begin tick(1'b0, 1'b0, 1'b0); npulse += o_vd_pulse; vd_dropped |= !o_ew_vd; end
      repeat (20) begin tick(1'b1, 1'b0, 1'b0); npulse += o_vd_pulse; vd_dropped |= !o_ew_vd; end
      chk("dropout_pulses", npulse, 0);
      chk("dropout_vd_drop", vd_dropped, 0);

      // 4: held fall -> detect clears after 27 edges
      edges = 0;
      do begin tick(1'b0, 1'b0, 1'b0); edges++; end while (o_ew_vd && edges < 60);
      chk("fall_latency", edges, SYNC + DEB + HOLD + 1);

      // 4b: re-arrival during hold (hold timer at 5) -> new vehicle strobe
      repeat (20) tick(1'b1, 1'b0, 1'b0);
      npulse = 0; vd_dropped = 0;
      repeat (14) begin tick(1'b0, 1'b0, 1'b0); npulse += o_vd_pulse; vd_dropped |= !o_ew_vd; end
      repeat (6) begin tick(1'b1, 1'b0, 1'b0); npulse += o_vd_pulse; vd_dropped |= !o_ew_vd; end
      chk("rehold_pulses", npulse, 1);
      chk("rehold_vd_drop", vd_dropped, 0);
`ifdef TLC_VD_COUNT_EN
      chk("count_three", o_veh_count, 3);
`endif

      // Drain to idle, then 2: five-cycle glitch from idle
      repeat (40) tick(1'b0, 1'b0, 1'b0);
      npulse = 0; edges = 0;
      repeat (5) begin tick(1'b1, 1'b0, 1'b0); npulse += o_vd_pulse; edges += o_ew_vd; end
      repeat (25) begin tick(1'b0, 1'b0, 1'b0); npulse += o_vd_pulse; edges += o_ew_vd; end
      chk("glitch_pulses", npulse, 0);
      chk("glitch_vd_cycles", edges, 0);

      // 5: stuck-on loop -> fault 100 edges after presence begins
      edges = 0;
      do begin tick(1'b1, 1'b0, 1'b0); edges++; end while (!o_ew_vd && edges < 40);
      edges = 0;
      do begin tick(1'b1, 1'b0, 1'b0); edges++; end while (!o_fault && edges < 300);
      chk("fault_latency", edges, STUCK);
      chk("fault_vd", o_ew_vd, 1);
      repeat (80) tick(1'b1, 1'b0, 1'b0);
      chk("fault_held", o_fault, 1);
      edges = 0;
      do begin tick(1'b0, 1'b0, 1'b0); edges++; end while (o_fault && edges < 60);
      chk("fault_release_latency", edges, SYNC + DEB);
      chk("fault_release_vd", o_ew_vd, 0);

      // 6: reset while present drops everything on the next edge
      repeat (15) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("midrst_vd", o_ew_vd, 0);
      chk("midrst_pulse", o_vd_pulse, 0);
      chk("midrst_fault", o_fault, 0);
`ifdef TLC_VD_COUNT_EN
      chk("midrst_count", o_veh_count, 0);
`endif

      // 6b: clear coinciding with the arrival strobe wins
      edges = 0;
      do begin tick(1'b1, 1'b0, 1'b0); edges++; end while (!o_vd_pulse && edges < 40);
      tick(1'b1, 1'b0, 1'b1);
`ifdef TLC_VD_COUNT_EN
      chk("clr_wins", o_veh_count, 0);
`endif

      // Randomized loop activity: short glitches, ordinary vehicles, stuck runs
      raw = 1'b1;
      for (int seg = 0; seg < 150; seg++) begin
         raw = ~raw;
         r = $urandom_range(0, 9);
         if (r < 4)      len = $urandom_range(1, DEB - 1);
         else if (r < 9) len = $urandom_range(DEB, 35);
         else            len = $urandom_range(STUCK, STUCK + 30);
         for (int k = 0; k < len; k++) begin
            tick(raw, ($urandom_range(0, 599) == 0), ($urandom_range(0, 24) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
